// File: rtl/quad_step_decoder_if.sv
// quad_step_decoder_if: phase inputs, clear and decoded outputs
// of the quadrature decoder, bundled for master/slave use.
interface quad_step_decoder_if #(
    parameter int WIDTH = 3
);
    logic             a_in;
    logic             b_in;
    logic             clr;
    logic             step;
    logic             dir;
    logic [WIDTH-1:0] pos;
    logic             err;

    modport master (
        output a_in, b_in, clr,
        input  step, dir, pos, err
    );

    modport slave (
        input  a_in, b_in, clr,
        output step, dir, pos, err
    );
endinterface

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: A/B quadrature decoder with step/dir and wrapping pos.
// Optional 4-cycle glitch filter enabled by defining QDEC_GLITCH_FILTER_EN.
module quad_step_decoder #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                rst,
    quad_step_decoder_if.slave bus
);
`ifdef QDEC_GLITCH_FILTER_EN
    localparam int FILT = 4;
`else
    localparam int FILT = 0;
`endif
    localparam int INIT_LAST = SYNC_STAGES + FILT;

    typedef enum logic {
        S_INIT,
        S_TRACK
    } state_t;

    logic [SYNC_STAGES-1:0] r_a_sync;
    logic [SYNC_STAGES-1:0] r_b_sync;
    logic [1:0]             w_ph;
    logic [1:0]             w_ph_q;
    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [1:0]             r_prev;
    logic                   r_step;
    logic                   r_dir;
    logic                   r_err;
    logic [WIDTH-1:0]       r_pos;
    logic [1:0]             w_delta;

    // Position of a phase pair along the forward Gray cycle.
    function automatic logic [1:0] f_idx(
        input logic [1:0] p
    );
        case (p)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_sync <= '0;
            r_b_sync <= '0;
        end else begin
            r_a_sync <= {r_a_sync[SYNC_STAGES-2:0], bus.a_in};
            r_b_sync <= {r_b_sync[SYNC_STAGES-2:0], bus.b_in};
        end
    end

    assign w_ph = {r_a_sync[SYNC_STAGES-1],
                   r_b_sync[SYNC_STAGES-1]};

`ifdef QDEC_GLITCH_FILTER_EN
    logic [1:0] r_h0;
    logic [1:0] r_h1;
    logic [1:0] r_h2;
    logic [1:0] r_filt;

    // Pass ph only once it has been seen on 4 consecutive edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h0   <= 2'b00;
            r_h1   <= 2'b00;
            r_h2   <= 2'b00;
            r_filt <= 2'b00;
        end else begin
            r_h0 <= w_ph;
            r_h1 <= r_h0;
            r_h2 <= r_h1;
            if (w_ph == r_h0 && r_h0 == r_h1 && r_h1 == r_h2)
                r_filt <= w_ph;
        end
    end

    assign w_ph_q = r_filt;
`else
    assign w_ph_q = w_ph;
`endif

    // 1 = forward, 3 = reverse, 2 = both bits changed.
    assign w_delta = f_idx(w_ph_q) - f_idx(r_prev);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_INIT;
            r_cnt   <= 4'd0;
            r_prev  <= 2'b00;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
            r_err   <= 1'b0;
            r_pos   <= '0;
        end else begin
            r_step <= 1'b0;
            r_prev <= w_ph_q;
            case (r_state)
                S_INIT: begin
                    if (r_cnt == 4'(INIT_LAST))
                        r_state <= S_TRACK;
                    else
                        r_cnt <= r_cnt + 4'd1;
                end
                S_TRACK: begin
                    case (w_delta)
                        2'd1: begin
                            r_step <= 1'b1;
                            r_dir  <= 1'b1;
                            r_pos  <= r_pos + WIDTH'(1);
                        end
                        2'd3: begin
                            r_step <= 1'b1;
                            r_dir  <= 1'b0;
                            r_pos  <= r_pos - WIDTH'(1);
                        end
                        2'd2:    r_err <= 1'b1;
                        default: ;
                    endcase
                    if (bus.clr) begin
                        r_pos <= '0;
                        r_err <= 1'b0;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign bus.step = r_step;
    assign bus.dir  = r_dir;
    assign bus.pos  = r_pos;
    assign bus.err  = r_err;
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: random phase stimulus with a Gray-cycle model;
// expected steps are queued and checked by a separate monitor.
module tb_quad_step_decoder;
    localparam int W   = 3;
    localparam int S   = 2;
    localparam int MOD = 1 << W;
`ifdef QDEC_GLITCH_FILTER_EN
    localparam int FILT = 4;
`else
    localparam int FILT = 0;
`endif
    localparam int LAT_E   = 1 + S + FILT;
    localparam int MIN_GAP = (FILT > 0) ? FILT + 1 : 1;
    localparam int INIT_W  = S + FILT + 4;

    typedef struct {
        int cyc;
        bit dir;
        int pos;
        bit err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] cur;
    int         m_pos;
    int         m_err;
    int         m_dir;

    quad_step_decoder_if #(.WIDTH(W)) bus ();

    quad_step_decoder #(
        .WIDTH      (W),
        .SYNC_STAGES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm,
                       input int act,
                       input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [1:0] p);
        for (int i = 0; i < 4; i++)
            if (gray[i] == p) return i;
        return 0;
    endfunction

    function automatic logic [1:0] fwd(input logic [1:0] p);
        return gray[(idx_of(p) + 1) % 4];
    endfunction

    function automatic logic [1:0] rev(input logic [1:0] p);
        return gray[(idx_of(p) + 3) % 4];
    endfunction

    task automatic drive_ph(input logic [1:0] nb,
                            input int gap,
                            input bit with_clr);
        int   d;
        exp_t e;
        d = (idx_of(nb) - idx_of(cur) + 4) % 4;
        bus.a_in = nb[1];
        bus.b_in = nb[0];
        if (d == 2) begin
            m_err = 1;
        end else if (d != 0) begin
            m_dir = (d == 1) ? 1 : 0;
            m_pos = (m_pos + ((d == 1) ? 1 : MOD - 1)) % MOD;
            if (with_clr) begin
                m_pos = 0;
                m_err = 0;
            end
            e.cyc = cyc + LAT_E;
            e.dir = m_dir[0];
            e.pos = m_pos;
            e.err = m_err[0];
            q.push_back(e);
        end
        cur = nb;
        if (with_clr) begin
            tick(LAT_E - 1);
            bus.clr = 1'b1;
            tick(1);
            bus.clr = 1'b0;
        end
        tick(gap);
    endtask

    task automatic clr_pulse();
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        m_pos = 0;
        m_err = 0;
        tick(1);
        chk("clr_pos", int'(bus.pos), 0);
        chk("clr_err", int'(bus.err), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && bus.step === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step: got step at cycle %0d expected none",
                         cyc);
            end else begin
                e = q.pop_front();
                chk("step_cycle", cyc, e.cyc);
                chk("step_dir", int'(bus.dir), int'(e.dir));
                chk("step_pos", int'(bus.pos), e.pos);
                chk("step_err", int'(bus.err), int'(e.err));
            end
        end
    end

    initial begin
        int r;
        int g;
        int guard;
        rst      = 1'b0;
        bus.a_in = 1'b0;
        bus.b_in = 1'b0;
        bus.clr  = 1'b0;
        cur      = 2'b00;
        m_pos    = 0;
        m_err    = 0;
        m_dir    = 0;

        tick(3);
        chk("rst_step", int'(bus.step), 0);
        chk("rst_dir", int'(bus.dir), 0);
        chk("rst_pos", int'(bus.pos), 0);
        chk("rst_err", int'(bus.err), 0);
        rst = 1'b1;
        tick(INIT_W);

        for (int i = 0; i < 4; i++)
            drive_ph(fwd(cur), 8, 1'b0);
        chk("fwd_pos", int'(bus.pos), 4);
        chk("fwd_dir", int'(bus.dir), 1);

        for (int i = 0; i < 8; i++)
            drive_ph(fwd(cur), MIN_GAP + 1, 1'b0);
        tick(LAT_E + 1);
        chk("wrap_pos", int'(bus.pos), 4);
        chk("wrap_err", int'(bus.err), 0);

        clr_pulse();
        drive_ph(rev(cur), 8, 1'b0);
        chk("rev_pos", int'(bus.pos), MOD - 1);
        chk("rev_dir", int'(bus.dir), 0);

        drive_ph(cur ^ 2'b11, 8, 1'b0);
        chk("ill_err", int'(bus.err), 1);
        chk("ill_pos", int'(bus.pos), MOD - 1);
        chk("ill_dir", int'(bus.dir), 0);

        drive_ph(fwd(cur), 4, 1'b1);
        chk("clrstep_pos", int'(bus.pos), 0);
        chk("clrstep_err", int'(bus.err), 0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            g = $urandom_range(MIN_GAP, MIN_GAP + 5);
            if (r < 45)
                drive_ph(fwd(cur), g, 1'b0);
            else if (r < 85)
                drive_ph(rev(cur), g, 1'b0);
            else if (r < 90)
                drive_ph(cur ^ 2'b11, g, 1'b0);
            else if (r < 95)
                drive_ph(cur, g, 1'b0);
            else begin
                tick(LAT_E + 2);
                clr_pulse();
            end
        end
        tick(LAT_E + 2);
        chk("rand_pos", int'(bus.pos), m_pos);
        chk("rand_err", int'(bus.err), m_err);

        while (cur != 2'b10)
            drive_ph(fwd(cur), MIN_GAP, 1'b0);
        tick(LAT_E + 2);
        clr_pulse();
        for (int i = 0; i < 5; i++)
            drive_ph(fwd(cur), MIN_GAP, 1'b0);
        tick(LAT_E + 2);
        chk("pre_rst_pos", int'(bus.pos), 5);
        chk("pre_rst_ph", int'(cur), 3);

        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("mid_rst_pos", int'(bus.pos), 0);
        chk("mid_rst_step", int'(bus.step), 0);
        chk("mid_rst_err", int'(bus.err), 0);
        m_pos = 0;
        m_err = 0;
        m_dir = 0;
        tick(3);
        rst = 1'b1;
        tick(INIT_W);
        chk("post_rst_err", int'(bus.err), 0);
        chk("post_rst_pos", int'(bus.pos), 0);
        drive_ph(2'b01, 8, 1'b0);
        chk("post_rst_fwd", int'(bus.pos), 1);
        chk("post_rst_dir", int'(bus.dir), 1);

`ifdef QDEC_GLITCH_FILTER_EN
        bus.a_in = ~bus.a_in;
        tick(2);
        bus.a_in = ~bus.a_in;
        tick(12);
        chk("glitch_pos", int'(bus.pos), m_pos);
        drive_ph(cur ^ 2'b10, 12, 1'b0);
        chk("filt_pos", int'(bus.pos), m_pos);
`endif

        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            tick(1);
            guard++;
        end
        chk("drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule
